// File: rtl/mem_fill_responder.sv
// Main-memory responder for the cache miss handlers: single-word reads/writes
// and aligned block fills, returned through a fixed-latency, non-stalling pipeline.
module mem_fill_responder #(
    parameter int DATA_W      = 16,
    parameter int MEM_WORDS   = 2048,
    parameter int LATENCY     = 4,
    parameter int BLOCK_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic              req_block,
    input  logic [15:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [15:0]       rsp_addr,
    output logic              rsp_last,
    output logic              busy
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int OFF_W  = $clog2(BLOCK_WORDS);
    localparam int BASE_W = 16 - OFF_W - 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [OFF_W-1:0]    cnt_r;
    logic [OFF_W-1:0]    cnt_s;
    logic [BASE_W-1:0]   base_r;
    logic [BASE_W-1:0]   base_s;

    logic                wr_en_s;
    logic                issue_s;
    logic                issue_last_s;
    logic [15:0]         issue_addr_s;
    logic [DATA_W-1:0]   issue_data_s;

    logic [DATA_W-1:0]   mem_r [MEM_WORDS];

    logic [LATENCY-1:0]              pv_r;
    logic [LATENCY-1:0]              pl_r;
    logic [LATENCY-1:0][DATA_W-1:0]  pd_r;
    logic [LATENCY-1:0][15:0]        pa_r;

    // Next-state, fill sequencing and issue decode
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        base_s       = base_r;
        wr_en_s      = 1'b0;
        issue_s      = 1'b0;
        issue_last_s = 1'b0;
        issue_addr_s = 16'h0000;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (req_wr) begin
                        wr_en_s = 1'b1;
                    end else if (req_block) begin
                        issue_s      = 1'b1;
                        issue_addr_s = {req_addr[15:OFF_W+1], {OFF_W{1'b0}}, 1'b0};
                        base_s       = req_addr[15:OFF_W+1];
                        cnt_s        = OFF_W'(1);
                        state_s      = FILL;
                    end else begin
                        issue_s      = 1'b1;
                        issue_last_s = 1'b1;
                        issue_addr_s = req_addr;
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            FILL: begin
                // Offset wraps inside the block: no carry into the base bits
                issue_s      = 1'b1;
                issue_addr_s = {base_r, cnt_r, 1'b0};
                if (cnt_r == OFF_W'(BLOCK_WORDS - 1)) begin
                    issue_last_s = 1'b1;
                    cnt_s        = {OFF_W{1'b0}};
                    state_s      = IDLE;
                end else begin
                    cnt_s = cnt_r + OFF_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {OFF_W{1'b0}};
            end
        endcase
    end

    // Array read at issue time; idle slots carry zero data
    always_comb begin
        issue_data_s = {DATA_W{1'b0}};
        if (issue_s) begin
            issue_data_s = mem_r[issue_addr_s[IDX_W:1]];
        end else begin
            issue_data_s = {DATA_W{1'b0}};
        end
    end

    // FSM state, fill counter and block base
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {OFF_W{1'b0}};
            base_r  <= {BASE_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            base_r  <= base_s;
        end
    end

    // Storage array; deliberately not reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[req_addr[IDX_W:1]] <= req_wdata;
        end
    end

    // Response pipeline: advances every cycle, never stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_r <= {LATENCY{1'b0}};
            pl_r <= {LATENCY{1'b0}};
            pd_r <= '0;
            pa_r <= '0;
        end else begin
            pv_r[0] <= issue_s;
            pl_r[0] <= issue_last_s;
            pd_r[0] <= issue_data_s;
            pa_r[0] <= issue_addr_s;
            for (int k = 1; k < LATENCY; k++) begin
                pv_r[k] <= pv_r[k-1];
                pl_r[k] <= pl_r[k-1];
                pd_r[k] <= pd_r[k-1];
                pa_r[k] <= pa_r[k-1];
            end
        end
    end

    assign req_ready = (state_r == IDLE);
    assign busy      = (state_r == FILL) | (|pv_r);
    assign rsp_valid = pv_r[LATENCY-1];
    assign rsp_last  = pl_r[LATENCY-1];
    assign rsp_data  = pd_r[LATENCY-1];
    assign rsp_addr  = pa_r[LATENCY-1];

endmodule

// File: tb/tb_mem_fill_responder.sv
// Directed plus randomized bench for mem_fill_responder, checked cycle by cycle
// against a per-cycle schedule of expected responses built from the request rules.
module tb_mem_fill_responder;

    localparam int LAT = 4;
    localparam int BW  = 8;
    localparam int NC  = 4096;

    typedef struct packed {
        logic        v;
        logic [15:0] d;
        logic [15:0] a;
        logic        l;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_wr;
    logic        req_block;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [15:0] rsp_addr;
    logic        rsp_last;
    logic        busy;

    logic [15:0] ref_mem [2048];
    rsp_t        exp_q [NC];
    int          cyc;
    int          ready_from;
    int          vectors;
    int          miscompares;

    mem_fill_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_wr    (req_wr),
        .req_block (req_block),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_addr  (rsp_addr),
        .rsp_last  (rsp_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int widx(input logic [15:0] a);
        return int'(a[11:1]);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $display("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
            $error("check %s", tag);
        end
    endtask

    // One clock cycle: present a request, check outputs at the falling edge, update the model
    task automatic tick(input logic v, input logic w, input logic b,
                        input logic [15:0] a, input logic [15:0] d);
        rsp_t        e;
        logic        rdy;
        logic        bsy;
        logic [15:0] ba;
        req_valid = v;
        req_wr    = w;
        req_block = b;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        e   = exp_q[cyc];
        rdy = (cyc >= ready_from);
        bsy = !rdy;
        for (int k = 0; k < LAT; k++) bsy = bsy | exp_q[cyc + k].v;
        chk("rsp_valid", 16'(rsp_valid), 16'(e.v));
        chk("rsp_data",  rsp_data,       e.d);
        chk("rsp_addr",  rsp_addr,       e.a);
        chk("rsp_last",  16'(rsp_last),  16'(e.l));
        chk("req_ready", 16'(req_ready), 16'(rdy));
        chk("busy",      16'(busy),      16'(bsy));
        if (v && rdy) begin
            if (w) begin
                ref_mem[widx(a)] = d;
            end else if (b) begin
                for (int k = 0; k < BW; k++) begin
                    ba = (a & 16'hFFF0) + 16'(2 * k);
                    exp_q[cyc + LAT + k] = '{v: 1'b1, d: ref_mem[widx(ba)], a: ba, l: (k == BW - 1)};
                end
                ready_from = cyc + BW;
            end else begin
                exp_q[cyc + LAT] = '{v: 1'b1, d: ref_mem[widx(a)], a: a, l: 1'b1};
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    // Asynchronous reset in the current cycle; in-flight responses are dropped
    task automatic mid_reset();
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #2;
        chk("rst_rsp_valid", 16'(rsp_valid), 16'h0000);
        chk("rst_busy",      16'(busy),      16'h0000);
        chk("rst_rsp_data",  rsp_data,       16'h0000);
        for (int t = cyc; t < NC; t++) exp_q[t] = '0;
        ready_from = 0;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        ready_from  = 0;
        for (int t = 0; t < NC; t++) exp_q[t] = '0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_block = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 16'(rsp_valid), 16'h0000);
        chk("reset_rsp_last",  16'(rsp_last),  16'h0000);
        chk("reset_rsp_data",  rsp_data,       16'h0000);
        chk("reset_rsp_addr",  rsp_addr,       16'h0000);
        chk("reset_busy",      16'(busy),      16'h0000);
        rst_n = 1'b1;

        // Preload the whole array so every later read has a known value
        for (int i = 0; i < 2048; i++) tick(1'b1, 1'b1, 1'b0, 16'(2 * i), 16'($urandom));
        idle(2);

        // Write then immediate read-back
        tick(1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF);
        tick(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        idle(6);

        // Block fill from an unaligned address, with a write attempted during the fill
        for (int k = 0; k < BW; k++) tick(1'b1, 1'b1, 1'b0, 16'(16'h0100 + 2 * k), 16'(16'hA000 + k));
        tick(1'b1, 1'b0, 1'b1, 16'h0106, 16'h0000);
        idle(2);
        tick(1'b1, 1'b1, 1'b0, 16'h0104, 16'h5555);
        idle(10);
        tick(1'b1, 1'b0, 1'b0, 16'h0104, 16'h0000);
        idle(6);

        // Back-to-back single reads
        tick(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick(1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000);
        tick(1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000);
        idle(6);

        // Read/write ordering on one word
        tick(1'b1, 1'b1, 1'b0, 16'h0020, 16'h1111);
        tick(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
        tick(1'b1, 1'b1, 1'b0, 16'h0020, 16'h2222);
        tick(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
        idle(6);

        // Top-of-space block: no wrap to 0x0000
        tick(1'b1, 1'b0, 1'b1, 16'hFFF6, 16'h0000);
        idle(12);

        // Randomized traffic, biased to a small region for hazards
        for (int i = 0; i < 800; i++) begin
            tick(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127)),
                 16'($urandom));
        end
        idle(12);

        // Reset in cycle 6 of a block fill
        tick(1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000);
        idle(5);
        mid_reset();
        idle(14);
        tick(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        tick(1'b1, 1'b0, 1'b1, 16'h010A, 16'h0000);
        idle(14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
